snake_frame_snapshot_ctrl: RTL and testbench

Sequences the per-frame snapshot of game state into the render-side registers that feed `snake_render_segments`. On each frame start it requests a freeze from the game logic, reads the body segments serially through a 1-cycle-latency read port, and commits head, apple, length and the packed body buses atomically. Because of this atomic commit the renderer never sees a torn frame. It sits in the top level, between the game state machine and the renderer.

---
 rtl/snake_frame_snapshot_ctrl.sv | 221 ++++++++++++++++++++++
 tb/tb_snake_frame_snapshot_ctrl.sv | 340 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/snake_frame_snapshot_ctrl.sv
// Per-frame snapshot sequencer: freezes game state, reads body segments
// serially and commits head/apple/length/body to the render registers at once.
module snake_frame_snapshot_ctrl #(
    parameter int unsigned CELL    = 10,
    parameter int unsigned MAX_LEN = 33,
    parameter int unsigned IDX_W   = 6
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   frame_start,
    input  logic                   active_start,
    output logic                   snap_req,
    input  logic                   snap_ack,
    input  logic [9:0]             head_x,
    input  logic [8:0]             head_y,
    input  logic [9:0]             apple_x,
    input  logic [8:0]             apple_y,
    input  logic [7:0]             snake_len,
    output logic                   seg_rd_en,
    output logic [IDX_W-1:0]       seg_rd_addr,
    input  logic [9:0]             seg_rd_x,
    input  logic [8:0]             seg_rd_y,
    output logic [9:0]             head_x_d,
    output logic [8:0]             head_y_d,
    output logic [9:0]             apple_x_d,
    output logic [8:0]             apple_y_d,
    output logic [7:0]             snake_len_d,
    output logic [MAX_LEN*10-1:0]  body_bus_x_d,
    output logic [MAX_LEN*9-1:0]   body_bus_y_d,
    output logic                   frame_latched,
    output logic                   frame_skipped
);

    localparam int unsigned X_W   = 10;
    localparam int unsigned Y_W   = 9;
    localparam int unsigned LEN_W = 8;
    localparam logic [LEN_W-1:0] MAX_LEN_L = LEN_W'(MAX_LEN);
    localparam bit PARAMS_OK = (CELL > 0) && ((1 << IDX_W) >= MAX_LEN) && (MAX_LEN < 256);

    // Reject parameter sets where the index cannot address every slot
    if (!PARAMS_OK) begin : g_bad_params
        $error("snake_frame_snapshot_ctrl: invalid CELL/MAX_LEN/IDX_W combination");
    end

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_COPY,
        S_COMMIT
    } state_t;

    state_t               state_q;
    state_t               state_nxt;

    logic [LEN_W-1:0]     lc_c;
    logic [LEN_W-1:0]     lc_q;
    logic [X_W-1:0]       sh_x [MAX_LEN];
    logic [Y_W-1:0]       sh_y [MAX_LEN];
    logic [X_W-1:0]       sh_apple_x;
    logic [Y_W-1:0]       sh_apple_y;
    logic [X_W-1:0]       body_x_q [MAX_LEN];
    logic [Y_W-1:0]       body_y_q [MAX_LEN];

    logic                 pend_q;
    logic [IDX_W-1:0]     pend_idx_q;

    logic                 snap_req_nxt;
    logic                 rd_en_nxt;
    logic [IDX_W-1:0]     rd_addr_nxt;
    logic                 latched_nxt;
    logic                 skipped_nxt;
    logic                 sample_c;
    logic                 capture_c;
    logic                 commit_c;
    logic                 last_issue_c;
    logic                 last_cap_c;

    // Clamp live length into 1..MAX_LEN
    always_comb begin
        lc_c = snake_len;
        if (snake_len == '0) begin
            lc_c = LEN_W'(1);
        end else if (snake_len > MAX_LEN_L) begin
            lc_c = MAX_LEN_L;
        end
    end

    assign last_issue_c = (LEN_W'(seg_rd_addr) >= (lc_q - LEN_W'(1)));
    assign last_cap_c   = pend_q && (LEN_W'(pend_idx_q) == (lc_q - LEN_W'(1)));

    // Next-state and next-output decode
    always_comb begin
        state_nxt   = state_q;
        rd_en_nxt   = 1'b0;
        rd_addr_nxt = seg_rd_addr;
        latched_nxt = 1'b0;
        skipped_nxt = 1'b0;
        sample_c    = 1'b0;
        capture_c   = 1'b0;
        commit_c    = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (frame_start && !active_start) begin
                    state_nxt = S_REQ;
                end
            end
            S_REQ: begin
                if (active_start) begin
                    state_nxt   = S_IDLE;
                    skipped_nxt = 1'b1;
                end else if (snap_ack) begin
                    sample_c = 1'b1;
                    if (lc_c >= LEN_W'(2)) begin
                        state_nxt   = S_COPY;
                        rd_en_nxt   = 1'b1;
                        rd_addr_nxt = IDX_W'(1);
                    end else begin
                        state_nxt = S_COMMIT;
                    end
                end
            end
            S_COPY: begin
                if (active_start) begin
                    state_nxt   = S_IDLE;
                    skipped_nxt = 1'b1;
                end else begin
                    capture_c = pend_q;
                    if (seg_rd_en && !last_issue_c) begin
                        rd_en_nxt   = 1'b1;
                        rd_addr_nxt = seg_rd_addr + IDX_W'(1);
                    end
                    if (last_cap_c) begin
                        state_nxt = S_COMMIT;
                    end
                end
            end
            S_COMMIT: begin
                commit_c    = 1'b1;
                latched_nxt = 1'b1;
                state_nxt   = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
        snap_req_nxt = (state_nxt != S_IDLE);
    end

    // State and control-output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            snap_req      <= 1'b0;
            seg_rd_en     <= 1'b0;
            seg_rd_addr   <= '0;
            frame_latched <= 1'b0;
            frame_skipped <= 1'b0;
            pend_q        <= 1'b0;
            pend_idx_q    <= '0;
        end else begin
            state_q       <= state_nxt;
            snap_req      <= snap_req_nxt;
            seg_rd_en     <= rd_en_nxt;
            seg_rd_addr   <= rd_addr_nxt;
            frame_latched <= latched_nxt;
            frame_skipped <= skipped_nxt;
            pend_q        <= (state_nxt == S_COPY) ? seg_rd_en : 1'b0;
            pend_idx_q    <= seg_rd_addr;
        end
    end

    // Shadow capture and atomic commit; slots at or above Lc keep old values
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lc_q        <= '0;
            sh_apple_x  <= '0;
            sh_apple_y  <= '0;
            head_x_d    <= '0;
            head_y_d    <= '0;
            apple_x_d   <= '0;
            apple_y_d   <= '0;
            snake_len_d <= '0;
            for (int k = 0; k < MAX_LEN; k++) begin
                sh_x[k]     <= '0;
                sh_y[k]     <= '0;
                body_x_q[k] <= '0;
                body_y_q[k] <= '0;
            end
        end else begin
            if (sample_c) begin
                lc_q       <= lc_c;
                sh_apple_x <= apple_x;
                sh_apple_y <= apple_y;
                sh_x[0]    <= head_x;
                sh_y[0]    <= head_y;
            end
            if (capture_c) begin
                sh_x[pend_idx_q] <= seg_rd_x;
                sh_y[pend_idx_q] <= seg_rd_y;
            end
            if (commit_c) begin
                head_x_d    <= sh_x[0];
                head_y_d    <= sh_y[0];
                apple_x_d   <= sh_apple_x;
                apple_y_d   <= sh_apple_y;
                snake_len_d <= lc_q;
                for (int k = 0; k < MAX_LEN; k++) begin
                    if (LEN_W'(k) < lc_q) begin
                        body_x_q[k] <= sh_x[k];
                        body_y_q[k] <= sh_y[k];
                    end
                end
            end
        end
    end

    // Pack committed slots, slot 0 in the most significant field
    for (genvar k = 0; k < MAX_LEN; k++) begin : g_pack
        assign body_bus_x_d[(MAX_LEN-k)*X_W-1 -: X_W] = body_x_q[k];
        assign body_bus_y_d[(MAX_LEN-k)*Y_W-1 -: Y_W] = body_y_q[k];
    end

endmodule

// File: tb/tb_snake_frame_snapshot_ctrl.sv
// Directed bench for snake_frame_snapshot_ctrl.
module tb_snake_frame_snapshot_ctrl;

    localparam int unsigned CELL    = 10;
    localparam int unsigned MAX_LEN = 33;
    localparam int unsigned IDX_W   = 6;

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic                  frame_start;
    logic                  active_start;
    logic                  snap_req;
    logic                  snap_ack;
    logic [9:0]            head_x;
    logic [8:0]            head_y;
    logic [9:0]            apple_x;
    logic [8:0]            apple_y;
    logic [7:0]            snake_len;
    logic                  seg_rd_en;
    logic [IDX_W-1:0]      seg_rd_addr;
    logic [9:0]            seg_rd_x;
    logic [8:0]            seg_rd_y;
    logic [9:0]            head_x_d;
    logic [8:0]            head_y_d;
    logic [9:0]            apple_x_d;
    logic [8:0]            apple_y_d;
    logic [7:0]            snake_len_d;
    logic [MAX_LEN*10-1:0] body_bus_x_d;
    logic [MAX_LEN*9-1:0]  body_bus_y_d;
    logic                  frame_latched;
    logic                  frame_skipped;

    int n_checks = 0;
    int n_errors = 0;
    int xoff = 0;
    int yoff = 0;

    logic [9:0] exp_x [MAX_LEN];
    logic [8:0] exp_y [MAX_LEN];
    logic [9:0] exp_ax;
    logic [8:0] exp_ay;
    logic [7:0] exp_len;

    snake_frame_snapshot_ctrl #(
        .CELL    (CELL),
        .MAX_LEN (MAX_LEN),
        .IDX_W   (IDX_W)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .frame_start   (frame_start),
        .active_start  (active_start),
        .snap_req      (snap_req),
        .snap_ack      (snap_ack),
        .head_x        (head_x),
        .head_y        (head_y),
        .apple_x       (apple_x),
        .apple_y       (apple_y),
        .snake_len     (snake_len),
        .seg_rd_en     (seg_rd_en),
        .seg_rd_addr   (seg_rd_addr),
        .seg_rd_x      (seg_rd_x),
        .seg_rd_y      (seg_rd_y),
        .head_x_d      (head_x_d),
        .head_y_d      (head_y_d),
        .apple_x_d     (apple_x_d),
        .apple_y_d     (apple_y_d),
        .snake_len_d   (snake_len_d),
        .body_bus_x_d  (body_bus_x_d),
        .body_bus_y_d  (body_bus_y_d),
        .frame_latched (frame_latched),
        .frame_skipped (frame_skipped)
    );

    always #5 clk = ~clk;

    // Segment store: 1-cycle read latency, data = (10k+xoff, 20k+yoff)
    always @(posedge clk) begin
        if (seg_rd_en) begin
            seg_rd_x <= 10'(10 * int'(seg_rd_addr) + xoff);
            seg_rd_y <= 9'(20 * int'(seg_rd_addr) + yoff);
        end
    end

    function automatic logic [9:0] seg_x(input int k);
        return 10'(10 * k + xoff);
    endfunction

    function automatic logic [8:0] seg_y(input int k);
        return 9'(20 * k + yoff);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_committed(input string tag);
        chk({tag, ":head_x_d"},    32'(head_x_d),    32'(exp_x[0]));
        chk({tag, ":head_y_d"},    32'(head_y_d),    32'(exp_y[0]));
        chk({tag, ":apple_x_d"},   32'(apple_x_d),   32'(exp_ax));
        chk({tag, ":apple_y_d"},   32'(apple_y_d),   32'(exp_ay));
        chk({tag, ":snake_len_d"}, 32'(snake_len_d), 32'(exp_len));
        for (int k = 0; k < MAX_LEN; k++) begin
            chk($sformatf("%s:slot_x[%0d]", tag, k),
                32'(body_bus_x_d[(MAX_LEN-k)*10-1 -: 10]), 32'(exp_x[k]));
            chk($sformatf("%s:slot_y[%0d]", tag, k),
                32'(body_bus_y_d[(MAX_LEN-k)*9-1 -: 9]), 32'(exp_y[k]));
        end
    endtask

    // One full snapshot: request, wait two cycles, ack, read body, commit
    task automatic do_frame(input string tag, input logic [7:0] len, input int lc,
                            input logic [9:0] hx, input logic [8:0] hy,
                            input logic [9:0] ax, input logic [8:0] ay,
                            input bit fs_in_copy, input bit as_in_commit);
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        chk({tag, ":snap_req_rise"}, 32'(snap_req), 1);
        tick();
        tick();
        chk({tag, ":req_wait_snap_req"}, 32'(snap_req), 1);
        chk({tag, ":req_wait_rd_en"}, 32'(seg_rd_en), 0);
        head_x    = hx;
        head_y    = hy;
        apple_x   = ax;
        apple_y   = ay;
        snake_len = len;
        snap_ack  = 1'b1;
        tick();
        for (int k = 1; k < lc; k++) begin
            chk($sformatf("%s:rd_en@%0d", tag, k), 32'(seg_rd_en), 1);
            chk($sformatf("%s:rd_addr@%0d", tag, k), 32'(seg_rd_addr), 32'(k));
            chk($sformatf("%s:latched@%0d", tag, k), 32'(frame_latched), 0);
            frame_start = fs_in_copy && (k == 2);
            tick();
            frame_start = 1'b0;
        end
        if (lc >= 2) begin
            chk({tag, ":last_cap_rd_en"}, 32'(seg_rd_en), 0);
            chk({tag, ":last_cap_latched"}, 32'(frame_latched), 0);
            tick();
        end
        chk({tag, ":commit_rd_en"}, 32'(seg_rd_en), 0);
        chk({tag, ":commit_latched"}, 32'(frame_latched), 0);
        chk({tag, ":commit_snap_req"}, 32'(snap_req), 1);
        chk({tag, ":pre_commit_head_x"}, 32'(head_x_d), 32'(exp_x[0]));
        active_start = as_in_commit;
        tick();
        active_start = 1'b0;
        exp_x[0] = hx;
        exp_y[0] = hy;
        for (int k = 1; k < lc; k++) begin
            exp_x[k] = seg_x(k);
            exp_y[k] = seg_y(k);
        end
        exp_ax  = ax;
        exp_ay  = ay;
        exp_len = 8'(lc);
        chk({tag, ":latched"}, 32'(frame_latched), 1);
        chk({tag, ":skipped"}, 32'(frame_skipped), 0);
        chk({tag, ":snap_req_fall"}, 32'(snap_req), 0);
        chk_committed(tag);
        snap_ack = 1'b0;
        tick();
        chk({tag, ":latched_pulse_end"}, 32'(frame_latched), 0);
        chk({tag, ":idle_snap_req"}, 32'(snap_req), 0);
    endtask

    initial begin
        rst_n        = 1'b0;
        frame_start  = 1'b0;
        active_start = 1'b0;
        snap_ack     = 1'b0;
        head_x       = '0;
        head_y       = '0;
        apple_x      = '0;
        apple_y      = '0;
        snake_len    = '0;
        seg_rd_x     = '0;
        seg_rd_y     = '0;
        for (int k = 0; k < MAX_LEN; k++) begin
            exp_x[k] = '0;
            exp_y[k] = '0;
        end
        exp_ax  = '0;
        exp_ay  = '0;
        exp_len = '0;

        // Reset state
        tick();
        tick();
        chk("rst:snap_req", 32'(snap_req), 0);
        chk("rst:rd_en", 32'(seg_rd_en), 0);
        chk("rst:rd_addr", 32'(seg_rd_addr), 0);
        chk("rst:latched", 32'(frame_latched), 0);
        chk("rst:skipped", 32'(frame_skipped), 0);
        chk_committed("rst");
        rst_n = 1'b1;
        tick();

        // Length 1: no reads, commit two cycles after ack
        do_frame("len1", 8'd1, 1, 10'd100, 9'd50, 10'd200, 9'd80, 1'b0, 1'b0);

        // Length 5: segments (10,20)..(40,80)
        xoff = 0;
        yoff = 0;
        do_frame("len5", 8'd5, 5, 10'd110, 9'd60, 10'd210, 9'd90, 1'b0, 1'b0);

        // frame_start with active_start in IDLE: no request, no pulse
        frame_start  = 1'b1;
        active_start = 1'b1;
        tick();
        frame_start  = 1'b0;
        active_start = 1'b0;
        chk("fs_as_idle:snap_req", 32'(snap_req), 0);
        chk("fs_as_idle:skipped", 32'(frame_skipped), 0);
        tick();
        chk("fs_as_idle:snap_req2", 32'(snap_req), 0);

        // Deadline in REQ with same-cycle ack: abort wins
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        chk("req_abort:snap_req", 32'(snap_req), 1);
        tick();
        head_x       = 10'd999;
        head_y       = 9'd333;
        apple_x      = 10'd777;
        apple_y      = 9'd222;
        snake_len    = 8'd3;
        snap_ack     = 1'b1;
        active_start = 1'b1;
        tick();
        active_start = 1'b0;
        snap_ack     = 1'b0;
        chk("req_abort:skipped", 32'(frame_skipped), 1);
        chk("req_abort:latched", 32'(frame_latched), 0);
        chk("req_abort:snap_req_fall", 32'(snap_req), 0);
        chk("req_abort:rd_en", 32'(seg_rd_en), 0);
        chk_committed("req_abort");
        tick();
        chk("req_abort:skipped_end", 32'(frame_skipped), 0);

        // Abort mid-COPY at address 3 of a length-10 read
        xoff = 3;
        yoff = 5;
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        tick();
        head_x    = 10'd500;
        head_y    = 9'd400;
        apple_x   = 10'd600;
        apple_y   = 9'd300;
        snake_len = 8'd10;
        snap_ack  = 1'b1;
        tick();
        chk("copy_abort:addr1", 32'(seg_rd_addr), 1);
        tick();
        chk("copy_abort:addr2", 32'(seg_rd_addr), 2);
        tick();
        chk("copy_abort:addr3", 32'(seg_rd_addr), 3);
        chk("copy_abort:rd_en3", 32'(seg_rd_en), 1);
        active_start = 1'b1;
        tick();
        active_start = 1'b0;
        snap_ack     = 1'b0;
        chk("copy_abort:skipped", 32'(frame_skipped), 1);
        chk("copy_abort:latched", 32'(frame_latched), 0);
        chk("copy_abort:snap_req_fall", 32'(snap_req), 0);
        chk("copy_abort:rd_en", 32'(seg_rd_en), 0);
        chk_committed("copy_abort");
        tick();
        chk("copy_abort:skipped_end", 32'(frame_skipped), 0);
        chk("copy_abort:addr_hold", 32'(seg_rd_addr), 3);

        // Following frame completes; frame_start in COPY ignored, deadline in COMMIT too late
        xoff = 1;
        yoff = 2;
        do_frame("len10", 8'd10, 10, 10'd520, 9'd410, 10'd610, 9'd310, 1'b1, 1'b1);

        // Clamp high: 200 -> 33, addresses to 32
        xoff = 4;
        yoff = 6;
        do_frame("len200", 8'd200, 33, 10'd20, 9'd30, 10'd40, 9'd70, 1'b0, 1'b0);

        // Clamp low: 0 -> 1, no reads, other slots untouched
        do_frame("len0", 8'd0, 1, 10'd321, 9'd123, 10'd654, 9'd456, 1'b0, 1'b0);

        // Async reset during COPY clears all outputs immediately
        xoff = 7;
        yoff = 9;
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        tick();
        snake_len = 8'd10;
        snap_ack  = 1'b1;
        tick();
        tick();
        chk("async_rst:in_copy", 32'(seg_rd_en), 1);
        #3;
        rst_n = 1'b0;
        #1;
        for (int k = 0; k < MAX_LEN; k++) begin
            exp_x[k] = '0;
            exp_y[k] = '0;
        end
        exp_ax  = '0;
        exp_ay  = '0;
        exp_len = '0;
        chk("async_rst:snap_req", 32'(snap_req), 0);
        chk("async_rst:rd_en", 32'(seg_rd_en), 0);
        chk("async_rst:rd_addr", 32'(seg_rd_addr), 0);
        chk("async_rst:latched", 32'(frame_latched), 0);
        chk("async_rst:skipped", 32'(frame_skipped), 0);
        chk_committed("async_rst");
        snap_ack = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        tick();
        chk("post_rst:snap_req", 32'(snap_req), 0);
        chk("post_rst:rd_en", 32'(seg_rd_en), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
